// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared elevator timing constants and timer channel state encoding
package elevator_pkg;

  // Default seconds prescale (50 MHz system clock) and seconds count width
  localparam int SEC_DIV = 50_000_000;
  localparam int SEC_W   = 4;

  typedef enum logic {
    TMR_IDLE = 1'b0,
    TMR_RUN  = 1'b1
  } tmr_state_e;

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one countdown channel (one-shot or auto-reload) driven by the seconds tick
module timer_channel
  import elevator_pkg::*;
#(
  parameter int CNT_W = SEC_W
) (
  input  logic             clk,
  input  logic             reseta,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             timeout
);

  tmr_state_e       state, state_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] reload, reload_nxt;
  logic             mode, mode_nxt;
  logic             timeout_nxt;

  // State, count, latched reload/mode and the registered expiry pulse
  always_ff @(posedge clk or negedge reseta) begin
    if (!reseta) begin
      state   <= TMR_IDLE;
      count   <= '0;
      reload  <= '0;
      mode    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      reload  <= reload_nxt;
      mode    <= mode_nxt;
      timeout <= timeout_nxt;
    end
  end

  // Next-state: stop beats start, start beats the seconds tick
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    reload_nxt  = reload;
    mode_nxt    = mode;
    timeout_nxt = 1'b0;
    if (stop) begin
      state_nxt = TMR_IDLE;
      count_nxt = '0;
    end else if (start) begin
      if (load_val != '0) begin
        state_nxt  = TMR_RUN;
        count_nxt  = load_val;
        reload_nxt = load_val;
        mode_nxt   = auto_reload;
      end else begin
        // A zero-length timer expires immediately without arming
        state_nxt   = TMR_IDLE;
        count_nxt   = '0;
        timeout_nxt = 1'b1;
      end
    end else if (tick && state == TMR_RUN) begin
      if (count > CNT_W'(1)) begin
        count_nxt = count - CNT_W'(1);
      end else if (count == CNT_W'(1)) begin
        timeout_nxt = 1'b1;
        if (mode) begin
          count_nxt = reload;
        end else begin
          count_nxt = '0;
          state_nxt = TMR_IDLE;
        end
      end
    end
  end

  assign busy = (state == TMR_RUN);

endmodule

// File: rtl/elevator_timer.sv
// rtl/elevator_timer.sv - seconds prescaler, free-running elapsed counter and NUM_CH countdown channels
module elevator_timer
  import elevator_pkg::*;
#(
  parameter int TICK_DIV = SEC_DIV,
  parameter int CNT_W    = SEC_W,
  parameter int NUM_CH   = 2
) (
  input  logic                    clk,
  input  logic                    reseta,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       auto_reload,
  input  logic [NUM_CH*CNT_W-1:0] load_val,
  output logic                    sec_tick,
  output logic [CNT_W-1:0]        elapsed,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       timeout
);

  localparam int PRE_W = $clog2(TICK_DIV);

  logic [PRE_W-1:0] pre;
  logic             pre_wrap;

  assign pre_wrap = (pre == PRE_W'(TICK_DIV - 1));

  // Prescaler; the tick is registered so it lands the cycle after the wrap
  always_ff @(posedge clk or negedge reseta) begin
    if (!reseta) begin
      pre      <= '0;
      sec_tick <= 1'b0;
    end else begin
      pre      <= pre_wrap ? '0 : pre + PRE_W'(1);
      sec_tick <= pre_wrap;
    end
  end

  // Free-running seconds counter, wraps silently
  always_ff @(posedge clk or negedge reseta) begin
    if (!reseta) begin
      elapsed <= '0;
    end else if (sec_tick) begin
      elapsed <= elapsed + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk        (clk),
      .reseta     (reseta),
      .tick       (sec_tick),
      .start      (start[i]),
      .stop       (stop[i]),
      .auto_reload(auto_reload[i]),
      .load_val   (load_val[i*CNT_W +: CNT_W]),
      .count      (count[i*CNT_W +: CNT_W]),
      .busy       (busy[i]),
      .timeout    (timeout[i])
    );
  end

endmodule

// File: tb/tb_elevator_timer.sv
// tb/tb_elevator_timer.sv - randomized self-checking bench for elevator_timer against a behavioural model
module tb_elevator_timer;

  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 4;
  localparam int NUM_CH   = 2;
  localparam int N_CYC    = 4000;

  logic                    clk = 1'b0;
  logic                    reseta;
  logic [NUM_CH-1:0]       start, stop, auto_reload;
  logic [NUM_CH*CNT_W-1:0] load_val;
  logic                    sec_tick;
  logic [CNT_W-1:0]        elapsed;
  logic [NUM_CH*CNT_W-1:0] count;
  logic [NUM_CH-1:0]       busy, timeout;

  elevator_timer #(
    .TICK_DIV(TICK_DIV),
    .CNT_W   (CNT_W),
    .NUM_CH  (NUM_CH)
  ) dut (
    .clk        (clk),
    .reseta     (reseta),
    .start      (start),
    .stop       (stop),
    .auto_reload(auto_reload),
    .load_val   (load_val),
    .sec_tick   (sec_tick),
    .elapsed    (elapsed),
    .count      (count),
    .busy       (busy),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: edges since reset release plus per-channel timer records
  int  m_edges;
  bit  m_tick;
  int  m_cnt  [NUM_CH];
  int  m_rl   [NUM_CH];
  bit  m_run  [NUM_CH];
  bit  m_auto [NUM_CH];
  bit  m_to   [NUM_CH];

  function automatic void model_reset();
    m_edges = 0;
    m_tick  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i] = 0; m_rl[i] = 0; m_run[i] = 0; m_auto[i] = 0; m_to[i] = 0;
    end
  endfunction

  function automatic int model_elapsed();
    if (m_edges == 0) return 0;
    return ((m_edges - 1) / TICK_DIV) % (1 << CNT_W);
  endfunction

  function automatic void model_edge(input logic [NUM_CH-1:0] st, input logic [NUM_CH-1:0] sp,
                                     input logic [NUM_CH-1:0] ar, input logic [NUM_CH*CNT_W-1:0] lv);
    bit tick_seen;
    int ld;
    tick_seen = m_tick;
    for (int i = 0; i < NUM_CH; i++) begin
      ld = int'(lv[i*CNT_W +: CNT_W]);
      m_to[i] = 0;
      if (sp[i]) begin
        m_run[i] = 0; m_cnt[i] = 0;
      end else if (st[i]) begin
        if (ld != 0) begin
          m_cnt[i] = ld; m_rl[i] = ld; m_auto[i] = ar[i]; m_run[i] = 1;
        end else begin
          m_to[i] = 1; m_run[i] = 0; m_cnt[i] = 0;
        end
      end else if (tick_seen && m_run[i]) begin
        if (m_cnt[i] > 1) m_cnt[i] = m_cnt[i] - 1;
        else begin
          m_to[i] = 1;
          if (m_auto[i]) m_cnt[i] = m_rl[i];
          else begin m_cnt[i] = 0; m_run[i] = 0; end
        end
      end
    end
    m_edges++;
    m_tick = (m_edges % TICK_DIV) == 0;
  endfunction

  task automatic compare_all(input string where);
    check_val({where, "_sec_tick"}, 32'(sec_tick), 32'(m_tick));
    check_val({where, "_elapsed"}, 32'(elapsed), 32'(model_elapsed()));
    for (int i = 0; i < NUM_CH; i++) begin
      check_val($sformatf("%s_count%0d", where, i), 32'(count[i*CNT_W +: CNT_W]), 32'(m_cnt[i]));
      check_val($sformatf("%s_busy%0d", where, i), 32'(busy[i]), 32'(m_run[i]));
      check_val($sformatf("%s_timeout%0d", where, i), 32'(timeout[i]), 32'(m_to[i]));
    end
  endtask

  task automatic check_all_zero(input string where);
    check_val({where, "_sec_tick"}, 32'(sec_tick), 32'd0);
    check_val({where, "_elapsed"}, 32'(elapsed), 32'd0);
    check_val({where, "_count"}, 32'(count), 32'd0);
    check_val({where, "_busy"}, 32'(busy), 32'd0);
    check_val({where, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    reseta = 1'b0; start = '0; stop = '0; auto_reload = '0; load_val = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    reseta = 1'b1;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      if (cyc > 100 && $urandom_range(0, 599) == 0) begin
        // Asynchronous reset asserted between edges must clear outputs at once
        start = '0; stop = '0;
        reseta = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        reseta = 1'b1;
        model_reset();
      end
      for (int i = 0; i < NUM_CH; i++) begin
        start[i]       = ($urandom_range(0, 11) == 0);
        stop[i]        = ($urandom_range(0, 29) == 0);
        auto_reload[i] = $urandom_range(0, 1) != 0;
        case ($urandom_range(0, 7))
          0:       load_val[i*CNT_W +: CNT_W] = '0;
          1:       load_val[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(1, 15));
          default: load_val[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(1, 4));
        endcase
      end
      // Long quiet stretch lets elapsed wrap and auto-reload repeat
      if (cyc >= 1000 && cyc < 1200) begin
        start = '0; stop = '0;
      end
      @(posedge clk);
      model_edge(start, stop, auto_reload, load_val);
      #1 compare_all("run");
      @(negedge clk);
      start = '0; stop = '0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
